yz_event_queue: RTL and testbench

Downstream consumer of the two-input priority encoder stage: each rising clock edge it samples the encoder's registered `y[1:0]`/`z[1:0]` outputs and classifies the pair as an A-event, a B-event or NONE. It collapses repeated events of the same class into a single entry and pushes each new event code into a small FIFO. The FIFO drains to a downstream reader over a valid/ready handshake. Per-class saturating counters and a sticky overflow flag give a bench or debug path a summary of encoder activity.

---
 rtl/yz_event_queue.sv | 142 ++++++++++++++
 tb/tb_yz_event_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/yz_event_queue.sv
// yz_event_queue: classifies the encoder's registered y/z pair as an A-event,
// a B-event or NONE, collapses runs of the same class into one event, and
// queues the event codes in a DEPTH-entry FIFO that drains over valid/ready.
// Saturating per-class counters and a sticky overflow flag summarise activity.
// Optional tracing: define YZ_EVENT_QUEUE_TRACE_EN to print push/pop/drop
// events and X warnings on z / y[1] (simulation only).
module yz_event_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       y,
  input  logic [1:0]       z,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [1:0]       out_code,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count,
  output logic             overflow
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  // Class encoding doubles as the FIFO entry code.
  localparam logic [1:0] ClsNone = 2'b00;
  localparam logic [1:0] ClsA    = 2'b01;
  localparam logic [1:0] ClsB    = 2'b10;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0]       cls;
  logic [1:0]       last_q, last_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] a_q, a_d, b_q, b_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       mem_q [DEPTH];
  logic             empty, full, pop, new_event, push;

  // y[0] is don't-care from the encoder.
  logic unused_y0;
  assign unused_y0 = y[0];

  // Classify the sampled pair; any X/Z makes the compares fail, giving NONE.
  always_comb begin
    cls = ClsNone;
    if (z == 2'b01 && y[1] == 1'b1) begin
      cls = ClsA;
    end else if (z == 2'b10 && y[1] == 1'b0) begin
      cls = ClsB;
    end
  end

  // FIFO status, event detection and next-state for pointers/counters/flag.
  always_comb begin
    empty     = (wptr_q == rptr_q);
    // Same slot, different lap bit: writer is a full lap ahead.
    full      = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    pop       = !empty && out_ready;
    new_event = (cls != ClsNone) && (cls != last_q);
    // A pop in the same cycle frees the slot the push needs.
    push      = new_event && (!full || pop);

    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
    last_d = cls;

    a_d = a_q;
    b_d = b_q;
    if (new_event && cls == ClsA && a_q != CntMax) begin
      a_d = a_q + CNT_W'(1);
    end
    if (new_event && cls == ClsB && b_q != CntMax) begin
      b_d = b_q + CNT_W'(1);
    end

    ovf_d = ovf_q | (new_event & ~push);
  end

  // Control state with synchronous reset; inputs in the reset cycle are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= ClsNone;
      a_q    <= '0;
      b_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
      a_q    <= a_d;
      b_q    <= b_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wptr_q[AddrW-1:0]] <= cls;
    end
  end

  // Head entry, forced to zero when empty.
  always_comb begin
    out_valid = !empty;
    out_code  = empty ? ClsNone : mem_q[rptr_q[AddrW-1:0]];
    a_count   = a_q;
    b_count   = b_q;
    overflow  = ovf_q;
  end

`ifdef YZ_EVENT_QUEUE_TRACE_EN
  logic [PtrW-1:0] occ_d;
  assign occ_d = wptr_d - rptr_d;

  // Trace accepted pushes, pops, drops and unknown inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        $display("%0t yz_event_queue: push code=%b occ=%0d", $time, cls, occ_d);
      end
      if (pop) begin
        $display("%0t yz_event_queue: pop code=%b occ=%0d", $time, out_code, occ_d);
      end
      if (new_event && !push) begin
        $display("%0t yz_event_queue: drop code=%b occ=%0d", $time, cls, occ_d);
      end
      if ($isunknown({z, y[1]})) begin
        $display("%0t yz_event_queue: warning, unknown value on z/y[1]", $time);
      end
    end
  end
`else
  // Tracing compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_yz_event_queue.sv
// Bench for yz_event_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_yz_event_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       y, z;
  logic             out_ready;
  logic             out_valid;
  logic [1:0]       out_code;
  logic [CNT_W-1:0] a_count, b_count;
  logic             overflow;

  yz_event_queue #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .z        (z),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_code (out_code),
    .a_count  (a_count),
    .b_count  (b_count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [1:0] mq [$];
  int         m_last;
  int         m_a, m_b;
  bit         m_ovf;
  // Codes seen leaving the DUT through completed handshakes.
  logic [1:0] obs [$];

  int n_err    = 0;
  int n_checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [1:0] yv, input logic [1:0] zv);
    if (zv == 2'b01 && yv[1] == 1'b1) return 1;
    if (zv == 2'b10 && yv[1] == 1'b0) return 2;
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] yv, input logic [1:0] zv,
                            input logic rd);
    int c;
    if (r) begin
      mq.delete();
      m_last = 0;
      m_a = 0;
      m_b = 0;
      m_ovf = 1'b0;
    end else begin
      c = cls_of(yv, zv);
      if (mq.size() > 0 && rd) void'(mq.pop_front());
      if (c != 0 && c != m_last) begin
        if (c == 1 && m_a < CNT_MAX) m_a++;
        if (c == 2 && m_b < CNT_MAX) m_b++;
        if (mq.size() < DEPTH) mq.push_back(c[1:0]);
        else m_ovf = 1'b1;
      end
      m_last = c;
    end
  endtask

  // One cycle: drive at the falling edge, update model at the rising edge,
  // compare 1 time unit later.
  task automatic step(input logic r, input logic [1:0] yv, input logic [1:0] zv,
                      input logic rd);
    rst = r; y = yv; z = zv; out_ready = rd;
    if (!r && out_valid && rd) obs.push_back(out_code);
    @(posedge clk);
    model_edge(r, yv, zv, rd);
    #1;
    check_eq("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
    check_eq("out_code", out_code, (mq.size() > 0) ? mq[0] : 2'b00);
    check_eq("a_count", a_count, m_a);
    check_eq("b_count", b_count, m_b);
    check_eq("overflow", overflow, m_ovf);
    @(negedge clk);
  endtask

  task automatic ev_a(input logic rd);
    step(1'b0, 2'b1x, 2'b01, rd);
  endtask

  task automatic ev_b(input logic rd);
    step(1'b0, 2'b00, 2'b10, rd);
  endtask

  task automatic idle(input logic rd);
    step(1'b0, 2'b00, 2'b00, rd);
  endtask

  task automatic do_reset();
    step(1'b1, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; y = 2'b00; z = 2'b00; out_ready = 1'b0;
    m_last = 0; m_a = 0; m_b = 0; m_ovf = 1'b0;
    @(negedge clk);

    // Reset then idle.
    do_reset();
    do_reset();
    repeat (5) idle(1'b0);
    check_eq("idle_valid", out_valid, 0);
    check_eq("idle_code", out_code, 0);
    check_eq("idle_ovf", overflow, 0);

    // Collapse: runs of A then B give one event each.
    obs.delete();
    repeat (3) ev_a(1'b1);
    repeat (3) ev_b(1'b1);
    repeat (2) idle(1'b1);
    check_eq("collapse_pops", obs.size(), 2);
    if (obs.size() == 2) begin
      check_eq("collapse_first", obs[0], 2'b01);
      check_eq("collapse_second", obs[1], 2'b10);
    end
    check_eq("collapse_a", a_count, 1);
    check_eq("collapse_b", b_count, 1);

    // Overflow: six alternating events into a stalled 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) ev_a(1'b0);
      else ev_b(1'b0);
    end
    check_eq("ovf_flag", overflow, 1);
    check_eq("ovf_a", a_count, 3);
    check_eq("ovf_b", b_count, 3);
    obs.delete();
    repeat (6) idle(1'b1);
    check_eq("ovf_drain_n", obs.size(), 4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      check_eq("ovf_drain_code", obs[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Full FIFO with a push and pop in the same cycle.
    do_reset();
    ev_a(1'b0); ev_b(1'b0); ev_a(1'b0); ev_b(1'b0);
    obs.delete();
    ev_a(1'b1);
    check_eq("fullpp_ovf", overflow, 0);
    check_eq("fullpp_valid", out_valid, 1);
    repeat (6) idle(1'b1);
    check_eq("fullpp_n", obs.size(), 5);
    for (int i = 0; i < obs.size() && i < 5; i++) begin
      check_eq("fullpp_code", obs[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Pointer wrap: 20 events, ready toggling 1-on/1-off.
    do_reset();
    obs.delete();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) ev_a(1'b0);
      else ev_b(1'b0);
      idle(1'b1);
    end
    repeat (4) idle(1'b1);
    check_eq("wrap_n", obs.size(), 20);
    for (int i = 0; i < obs.size() && i < 20; i++) begin
      check_eq("wrap_code", obs[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    check_eq("wrap_ovf", overflow, 0);

    // Reset mid-operation with an A-event on the inputs.
    do_reset();
    ev_a(1'b1); idle(1'b1); ev_a(1'b1); idle(1'b1);
    ev_a(1'b0); idle(1'b0); ev_a(1'b0); idle(1'b0); ev_a(1'b0);
    check_eq("pre_rst_a", a_count, 5);
    step(1'b1, 2'b1x, 2'b01, 1'b0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_code", out_code, 0);
    check_eq("rst_a", a_count, 0);
    check_eq("rst_b", b_count, 0);
    check_eq("rst_ovf", overflow, 0);
    idle(1'b1);
    check_eq("post_rst_valid", out_valid, 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      ev_a(1'b1);
      ev_b(1'b1);
    end
    check_eq("sat_a", a_count, CNT_MAX);
    check_eq("sat_b", b_count, CNT_MAX);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), 2'($urandom), 2'($urandom),
           ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
